uart_byte_fifo: RTL and testbench
=================================

Name: uart_byte_fifo

Overview:
Byte buffer between the UART receiver and the UART transmitter in the loopback/echo path. It accepts single-cycle byte strobes from the RX side, stores them in a circular FIFO, and drains them one at a time into the TX side. It uses a tx_start/tx_busy launch handshake, so back-to-back received bytes are not lost while TX is still sending. It also reports fill level and a sticky overflow flag for status/LED logic.

Parameters:
DEPTH, 16, number of byte entries; power of 2, minimum 2
AW, 4, pointer width = log2(DEPTH)
BUSY_TO, 3, cycles to wait for tx_busy to rise after a launch before giving up

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
wr_data  input  8  byte from receiver
wr_en  input  1  one-cycle strobe; writes wr_data
drain_en  input  1  1 = launches to TX allowed; 0 = hold contents
tx_busy  input  1  transmitter busy
tx_start  output  1  one-cycle launch strobe to transmitter (registered)
tx_data  output  8  byte for transmitter; valid with tx_start and held until next launch
level  output  AW+1  current entry count, 0..DEPTH
empty  output  1  level == 0
full  output  1  level == DEPTH
overflow  output  1  sticky; set when a write is dropped
ovf_clr  input  1  clears overflow

Behaviour:
- Reset (async, immediate): tx_start=0, tx_data=8'h00, level=0, empty=1, full=0, overflow=0, pointers=0, state=IDLE. Memory contents are not reset.
- Storage: mem[DEPTH] x 8. wr_ptr and rd_ptr are AW bits and wrap DEPTH-1 -> 0 naturally. level is a separate AW+1-bit counter.
- Write: if wr_en && (!full || pop_this_cycle), then mem[wr_ptr]<=wr_data and wr_ptr++.
- Dropped write: if wr_en && full && !pop_this_cycle, the data is discarded and overflow<=1.
- Overflow priority: if a set and ovf_clr occur in the same cycle, set wins.
- level update: +1 on accepted write only; -1 on pop only; unchanged when both occur in the same cycle.
- empty and full are combinational from level.
- Drain FSM:
  - IDLE: if drain_en && !empty && !tx_busy, pop_this_cycle=1. The FSM registers tx_data<=mem[rd_ptr], tx_start<=1, rd_ptr++, and goes to WAIT_BUSY with timer=0.
  - WAIT_BUSY: tx_start<=0. If tx_busy=1, go to WAIT_DONE. Else timer++; when timer reaches BUSY_TO, go to IDLE (TX assumed to have completed or ignored the strobe; no retry, byte counted as sent).
  - WAIT_DONE: when tx_busy=0, go to IDLE.
- Latency:
  - Write into empty FIFO at cycle N, drain_en=1, tx_busy=0: tx_start is high in cycle N+2. level reads 1 at N+1, then 0 at N+2.
  - Minimum launch spacing is 3 cycles.
- tx_start is exactly one cycle wide, never asserted outside the IDLE->WAIT_BUSY transition.
- Read-before-write: a write to the same address as a concurrent pop never corrupts the popped byte. Pop reads the old entry; with level≥1 the addresses differ except when full, where the read is of the old data.
- Dropping drain_en mid-transfer does not abort WAIT_BUSY/WAIT_DONE; it only blocks the next launch.
- rst mid-transfer: FSM returns to IDLE, all buffered bytes are discarded, and tx_start deasserts immediately.

Optional Feature:
UART_BYTE_FIFO_SCAN_EN
- Defined: adds ports scan_enable (in, 1), scan_in (in, 1), scan_out (out, 1).
- When scan_enable=1, all control flops form one shift chain per clk. Chain order, scan_in first: state(2), timer(2), wr_ptr(AW), rd_ptr(AW), level(AW+1), overflow, tx_start; scan_out = tx_start flop.
- While scan_enable=1, functional updates and memory writes are suppressed.
- Reset still has priority over shifting.
- Not defined: no scan ports, no chain muxing, identical functional behaviour.

Test Plan:
- After reset, wr_en with bytes 8'h41,8'h42,8'h43 on consecutive cycles, drain_en=1, and a TX model that raises busy 1 cycle after tx_start and holds it 10 cycles -> tx_data sequence 41,42,43, one tx_start per byte, level returns to 0, overflow=0.
- drain_en=0, write 17 bytes 0x00..0x10 -> full=1 after 16, level=16, 17th dropped, overflow=1. Enable drain -> bytes 0x00..0x0F out, 0x10 never appears.
- Full FIFO with wr_en and pop in the same cycle -> write accepted, level stays 16, overflow stays 0. The popped byte equals the oldest entry.
- tx_busy tied 0 -> after tx_start, FSM returns to IDLE after BUSY_TO=3 cycles; next launch 5 cycles after the previous one; no hang.
- Write 20 bytes with interleaved draining so pointers wrap past 15 -> output order is preserved across the wrap.
- Assert rst while in WAIT_DONE with level=5 -> next cycle level=0, empty=1, tx_start=0. ovf_clr with a simultaneous drop -> overflow stays 1.

Source files
------------

// File: rtl/uart_byte_fifo_if.sv
// Byte-stream and status bundle between the UART echo path and uart_byte_fifo.
// master = RX/TX/status side, slave = the FIFO itself.
interface uart_byte_fifo_if #(
    parameter int AW = 4
);
    logic [7:0]  wr_data;
    logic        wr_en;
    logic        drain_en;
    logic        tx_busy;
    logic        ovf_clr;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [AW:0] level;
    logic        empty;
    logic        full;
    logic        overflow;

    modport master (
        output wr_data, wr_en, drain_en, tx_busy, ovf_clr,
        input  tx_start, tx_data, level, empty, full, overflow
    );

    modport slave (
        input  wr_data, wr_en, drain_en, tx_busy, ovf_clr,
        output tx_start, tx_data, level, empty, full, overflow
    );
endinterface

// File: rtl/uart_byte_fifo.sv
// Circular byte FIFO between UART RX and TX with a tx_start/tx_busy drain FSM.
// Optional scan chain over the control flops: define UART_BYTE_FIFO_SCAN_EN.
module uart_byte_fifo #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int BUSY_TO = 3
) (
    input  logic            clk,
    input  logic            rst,
`ifdef UART_BYTE_FIFO_SCAN_EN
    input  logic            scan_enable,
    input  logic            scan_in,
    output logic            scan_out,
`endif
    uart_byte_fifo_if.slave bus
);
    localparam int          TW       = 2;
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [TW-1:0] TO_CNT = TW'(BUSY_TO);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_timer;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_level;
    logic            r_overflow;
    logic            r_tx_start;
    logic [7:0]      r_tx_data;
    logic [7:0]      r_mem [DEPTH];

    logic            w_hold;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_wr_accept;
    logic            w_drop;

`ifdef UART_BYTE_FIFO_SCAN_EN
    localparam int   CW = 2 + TW + 2*AW + (AW+1) + 2;
    logic [CW-1:0]   w_chain;
    logic [CW-1:0]   w_shift;

    // scan_in enters the state MSB; tx_start is the last flop in the chain
    assign w_hold   = scan_enable;
    assign w_chain  = {r_state, r_timer, r_wr_ptr, r_rd_ptr, r_level, r_overflow, r_tx_start};
    assign w_shift  = {scan_in, w_chain[CW-1:1]};
    assign scan_out = r_tx_start;
`else
    assign w_hold   = 1'b0;
`endif

    assign w_empty     = (r_level == '0);
    assign w_full      = (r_level == FULL_LVL);
    assign w_pop       = (r_state == IDLE) && bus.drain_en && !w_empty && !bus.tx_busy && !w_hold;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a write then
    assign w_wr_accept = bus.wr_en && (!w_full || w_pop) && !w_hold;
    assign w_drop      = bus.wr_en && w_full && !w_pop && !w_hold;

    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
        end
`ifdef UART_BYTE_FIFO_SCAN_EN
        else if (w_hold) begin
            r_state    <= state_t'(w_shift[CW-1 -: 2]);
            r_timer    <= w_shift[CW-3 -: TW];
            r_wr_ptr   <= w_shift[CW-3-TW -: AW];
            r_rd_ptr   <= w_shift[CW-3-TW-AW -: AW];
            r_level    <= w_shift[AW+2 -: AW+1];
            r_overflow <= w_shift[1];
            r_tx_start <= w_shift[0];
        end
`endif
        else begin
            r_tx_start <= 1'b0;

            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.ovf_clr) begin
                r_overflow <= 1'b0;
            end

            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            case ({w_wr_accept, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase

            // No retry on timeout: the launched byte is treated as sent
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_tx_data  <= r_mem[r_rd_ptr];
                        r_tx_start <= 1'b1;
                        r_rd_ptr   <= r_rd_ptr + 1'b1;
                        r_timer    <= '0;
                        r_state    <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        r_state <= WAIT_DONE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                        if (r_timer == TO_CNT) begin
                            r_state <= IDLE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.tx_start = r_tx_start;
    assign bus.tx_data  = r_tx_data;
    assign bus.level    = r_level;
    assign bus.empty    = w_empty;
    assign bus.full     = w_full;
    assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_uart_byte_fifo.sv
// Directed bench for uart_byte_fifo: echo path, overflow, full read/write, timeout, wrap, reset.
`timescale 1ns/1ps
module tb_uart_byte_fifo;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_byte_fifo_if #(.AW(4)) bus();

    logic model_en;
    logic force_busy;
    logic model_busy   = 1'b0;
    logic tx_pend      = 1'b0;
    logic prev_start   = 1'b0;
    int   busy_cnt     = 0;
    int   start_pulses = 0;
    int   double_start = 0;
    logic [7:0] captured [$];

    int checks   = 0;
    int failures = 0;

    assign bus.tx_busy = model_en ? model_busy : force_busy;

    uart_byte_fifo #(.DEPTH(16), .AW(4), .BUSY_TO(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Launch monitor plus TX model: busy rises one cycle after tx_start and holds 10 cycles
    always @(negedge clk) begin
        if (bus.tx_start === 1'b1) begin
            captured.push_back(bus.tx_data);
            if (prev_start) double_start++;
            else start_pulses++;
        end
        prev_start = (bus.tx_start === 1'b1);
        if (tx_pend) begin
            model_busy = 1'b1;
            busy_cnt   = 10;
            tx_pend    = 1'b0;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) model_busy = 1'b0;
        end
        if (bus.tx_start === 1'b1 && model_en) tx_pend = 1'b1;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [7:0] cap(input int idx);
        if (idx < captured.size()) return captured[idx];
        return 8'hxx;
    endfunction

    task automatic write_byte(input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_captured(input int target, input int bound);
        int n = 0;
        while (captured.size() < target && n < bound) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        checks++; if (bus.tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start got=%0b exp=0", bus.tx_start); end
        checks++; if (bus.tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%02h exp=00", bus.tx_data); end
        checks++; if (bus.level !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", bus.level); end
        checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0b exp=1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", bus.full); end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", bus.overflow); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_latency();
        bus.drain_en = 1'b1;
        force_busy   = 1'b0;
        model_en     = 1'b0;
        bus.wr_en    = 1'b1;
        bus.wr_data  = 8'h5A;
        step();
        bus.wr_en = 1'b0;
        checks++; if (bus.level !== 5'd1) begin failures++; $display("FAIL lat_level_n1 got=%0d exp=1", bus.level); end
        checks++; if (bus.tx_start !== 1'b0) begin failures++; $display("FAIL lat_start_n1 got=%0b exp=0", bus.tx_start); end
        step();
        checks++; if (bus.tx_start !== 1'b1) begin failures++; $display("FAIL lat_start_n2 got=%0b exp=1", bus.tx_start); end
        checks++; if (bus.tx_data !== 8'h5A) begin failures++; $display("FAIL lat_data got=%02h exp=5a", bus.tx_data); end
        checks++; if (bus.level !== 5'd0 || bus.empty !== 1'b1) begin failures++; $display("FAIL lat_level_n2 got=%0d/%0b exp=0/1", bus.level, bus.empty); end
        step();
        checks++; if (bus.tx_start !== 1'b0) begin failures++; $display("FAIL lat_start_width got=%0b exp=0", bus.tx_start); end
        idle(8);
    endtask

    task automatic test_busy_timeout();
        int t1 = -1;
        int t2 = -1;
        int n  = 0;
        bus.drain_en = 1'b0;
        force_busy   = 1'b0;
        write_byte(8'hAA);
        write_byte(8'hBB);
        bus.drain_en = 1'b1;
        while (t2 < 0 && n < 30) begin
            step();
            n++;
            if (bus.tx_start === 1'b1) begin
                if (t1 < 0) begin
                    t1 = n;
                    checks++; if (bus.tx_data !== 8'hAA) begin failures++; $display("FAIL to_first_data got=%02h exp=aa", bus.tx_data); end
                end else begin
                    t2 = n;
                    checks++; if (bus.tx_data !== 8'hBB) begin failures++; $display("FAIL to_second_data got=%02h exp=bb", bus.tx_data); end
                end
            end
        end
        checks++; if (t2 - t1 !== 5 || t1 < 0) begin failures++; $display("FAIL to_spacing got=%0d exp=5", t2 - t1); end
        idle(10);
        checks++; if (bus.level !== 5'd0 || bus.tx_start !== 1'b0) begin failures++; $display("FAIL to_settle level=%0d start=%0b exp=0/0", bus.level, bus.tx_start); end
    endtask

    task automatic test_echo();
        int base   = captured.size();
        int pulses = start_pulses;
        model_en     = 1'b1;
        bus.drain_en = 1'b1;
        write_byte(8'h41);
        write_byte(8'h42);
        write_byte(8'h43);
        wait_captured(base + 3, 100);
        idle(20);
        checks++; if (captured.size() - base !== 3) begin failures++; $display("FAIL echo_count got=%0d exp=3", captured.size() - base); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (cap(base + i) !== 8'h41 + 8'(i)) begin failures++; $display("FAIL echo_data[%0d] got=%02h exp=%02h", i, cap(base + i), 8'h41 + 8'(i)); end
        end
        checks++; if (start_pulses - pulses !== 3 || double_start !== 0) begin failures++; $display("FAIL echo_pulses got=%0d wide=%0d exp=3/0", start_pulses - pulses, double_start); end
        checks++; if (bus.level !== 5'd0 || bus.overflow !== 1'b0) begin failures++; $display("FAIL echo_final level=%0d ovf=%0b exp=0/0", bus.level, bus.overflow); end
    endtask

    task automatic test_overflow_drain();
        int base;
        bus.drain_en = 1'b0;
        for (int i = 0; i < 16; i++) write_byte(8'(i));
        checks++; if (bus.full !== 1'b1 || bus.level !== 5'd16) begin failures++; $display("FAIL ovf_full full=%0b level=%0d exp=1/16", bus.full, bus.level); end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL ovf_pre got=%0b exp=0", bus.overflow); end
        write_byte(8'h10);
        checks++; if (bus.overflow !== 1'b1 || bus.level !== 5'd16) begin failures++; $display("FAIL ovf_drop ovf=%0b level=%0d exp=1/16", bus.overflow, bus.level); end
        base = captured.size();
        bus.drain_en = 1'b1;
        wait_captured(base + 16, 400);
        idle(20);
        checks++; if (captured.size() - base !== 16) begin failures++; $display("FAIL ovf_count got=%0d exp=16", captured.size() - base); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (cap(base + i) !== 8'(i)) begin failures++; $display("FAIL ovf_data[%0d] got=%02h exp=%02h", i, cap(base + i), 8'(i)); end
        end
        checks++; if (bus.empty !== 1'b1 || bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky empty=%0b ovf=%0b exp=1/1", bus.empty, bus.overflow); end
        bus.ovf_clr = 1'b1;
        step();
        bus.ovf_clr = 1'b0;
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%0b exp=0", bus.overflow); end
    endtask

    task automatic test_ovf_clr_drop();
        bus.drain_en = 1'b0;
        for (int i = 0; i < 16; i++) write_byte(8'h80 + 8'(i));
        bus.ovf_clr = 1'b1;
        write_byte(8'hEE);
        bus.ovf_clr = 1'b0;
        checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL clr_drop_set_wins got=%0b exp=1", bus.overflow); end
        bus.ovf_clr = 1'b1;
        step();
        bus.ovf_clr = 1'b0;
        checks++; if (bus.overflow !== 1'b0 || bus.level !== 5'd16) begin failures++; $display("FAIL clr_drop_after ovf=%0b level=%0d exp=0/16", bus.overflow, bus.level); end
    endtask

    task automatic test_full_simul();
        int base;
        bus.drain_en = 1'b1;
        bus.wr_en    = 1'b1;
        bus.wr_data  = 8'hC3;
        step();
        bus.wr_en    = 1'b0;
        bus.drain_en = 1'b0;
        checks++; if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h80) begin failures++; $display("FAIL fs_pop start=%0b data=%02h exp=1/80", bus.tx_start, bus.tx_data); end
        checks++; if (bus.level !== 5'd16 || bus.full !== 1'b1) begin failures++; $display("FAIL fs_level level=%0d full=%0b exp=16/1", bus.level, bus.full); end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL fs_overflow got=%0b exp=0", bus.overflow); end
        base = captured.size();
        bus.drain_en = 1'b1;
        wait_captured(base + 16, 400);
        idle(20);
        for (int i = 0; i < 16; i++) begin
            logic [7:0] exp_b;
            exp_b = (i < 15) ? 8'h81 + 8'(i) : 8'hC3;
            checks++; if (cap(base + i) !== exp_b) begin failures++; $display("FAIL fs_data[%0d] got=%02h exp=%02h", i, cap(base + i), exp_b); end
        end
        checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL fs_empty got=%0b exp=1", bus.empty); end
    endtask

    task automatic test_wrap();
        int base = captured.size();
        model_en     = 1'b0;
        force_busy   = 1'b0;
        bus.drain_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            write_byte(8'hE0 + 8'(i));
            step();
        end
        wait_captured(base + 20, 300);
        idle(10);
        checks++; if (captured.size() - base !== 20) begin failures++; $display("FAIL wrap_count got=%0d exp=20", captured.size() - base); end
        for (int i = 0; i < 20; i++) begin
            checks++; if (cap(base + i) !== 8'hE0 + 8'(i)) begin failures++; $display("FAIL wrap_data[%0d] got=%02h exp=%02h", i, cap(base + i), 8'hE0 + 8'(i)); end
        end
        checks++; if (bus.level !== 5'd0 || bus.overflow !== 1'b0) begin failures++; $display("FAIL wrap_final level=%0d ovf=%0b exp=0/0", bus.level, bus.overflow); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int pulses;
        model_en     = 1'b1;
        bus.drain_en = 1'b0;
        for (int i = 0; i < 6; i++) write_byte(8'h61 + 8'(i));
        bus.drain_en = 1'b1;
        while (bus.tx_start !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        bus.drain_en = 1'b0;
        checks++; if (bus.tx_data !== 8'h61 || bus.level !== 5'd5) begin failures++; $display("FAIL rm_launch data=%02h level=%0d exp=61/5", bus.tx_data, bus.level); end
        idle(3);
        checks++; if (bus.level !== 5'd5 || bus.tx_busy !== 1'b1) begin failures++; $display("FAIL rm_wait_done level=%0d busy=%0b exp=5/1", bus.level, bus.tx_busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.level !== 5'd0 || bus.empty !== 1'b1 || bus.tx_start !== 1'b0) begin failures++; $display("FAIL rm_async level=%0d empty=%0b start=%0b exp=0/1/0", bus.level, bus.empty, bus.tx_start); end
        step();
        rst = 1'b0;
        step();
        pulses = start_pulses;
        bus.drain_en = 1'b1;
        idle(20);
        checks++; if (start_pulses !== pulses || bus.level !== 5'd0) begin failures++; $display("FAIL rm_discard pulses=%0d level=%0d exp=0/0", start_pulses - pulses, bus.level); end
    endtask

    initial begin
        rst          = 1'b1;
        model_en     = 1'b0;
        force_busy   = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_data  = 8'h00;
        bus.drain_en = 1'b0;
        bus.ovf_clr  = 1'b0;
        test_reset();
        test_latency();
        test_busy_timeout();
        test_echo();
        test_overflow_drain();
        test_ovf_clr_drop();
        test_full_simul();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
